// File: rtl/sdes_decrypt_seq_if.sv
// Purpose: block-in / plaintext-out bundle for the S-DES decryption core.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
//
// Ports: in_valid, in_ready, key[0:9], ciphertext[0:7] (index 0 = standard MSB bit 1),
//        out_valid, out_ready, plaintext[0:7], busy.
//        master = block source/sink (testbench or link logic), slave = the core.
interface sdes_decrypt_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [0:9] key;
  logic [0:7] ciphertext;
  logic       out_valid;
  logic       out_ready;
  logic [0:7] plaintext;
  logic       busy;

  modport master (
    output in_valid, key, ciphertext, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );

  modport slave (
    input  in_valid, key, ciphertext, out_ready,
    output in_ready, out_valid, plaintext, busy
  );
endinterface

// File: rtl/sdes_decrypt_seq.sv
// Purpose: multi-cycle S-DES decryption, IP -> fk(K2) -> SW -> fk(K1) -> IP^-1.
// Latency: accept edge to out_valid is 3 edges, 2 when the stored subkeys are reused.
// Backpressure: plaintext/out_valid held in DONE until out_ready; in_ready only in IDLE.
//
// Ports: clk (rising edge), rst_n (async active-low), bus (sdes_decrypt_seq_if.slave).
// Bit vectors are ascending ([0:N-1]) so index n-1 is standard S-DES bit n.
module sdes_decrypt_seq #(
  parameter bit REUSE_KEY = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  sdes_decrypt_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, KEYGEN, ROUND1, ROUND2, DONE} state_t;

  // Row-major tables, indexed by {row, col} = {b1, b4, b2, b3}.
  localparam logic [1:0] S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                     2'd3, 2'd2, 2'd1, 2'd0,
                                     2'd0, 2'd2, 2'd1, 2'd3,
                                     2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                     2'd2, 2'd0, 2'd1, 2'd3,
                                     2'd3, 2'd0, 2'd1, 2'd0,
                                     2'd2, 2'd1, 2'd0, 2'd3};

  function automatic logic [0:7] p8(input logic [0:9] v);
    return {v[5], v[2], v[6], v[3], v[7], v[4], v[9], v[8]};
  endfunction

  // Returns {K1, K2}.
  function automatic logic [0:15] keygen(input logic [0:9] k);
    logic [0:9] p;
    logic [0:4] l1, r1, l2, r2;
    p  = {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
    l1 = {p[1:4], p[0]};
    r1 = {p[6:9], p[5]};
    l2 = {l1[2:4], l1[0:1]};
    r2 = {r1[2:4], r1[0:1]};
    return {p8({l1, r1}), p8({l2, r2})};
  endfunction

  function automatic logic [0:3] f_fn(input logic [0:3] r, input logic [0:7] sk);
    logic [0:7] t;
    logic [0:1] a, b;
    t = {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]} ^ sk;
    a = S0[{t[0], t[3], t[1], t[2]}];
    b = S1[{t[4], t[7], t[5], t[6]}];
    return {a[1], b[1], b[0], a[0]};
  endfunction

  function automatic logic [0:7] fk(input logic [0:7] x, input logic [0:7] sk);
    return {x[0:3] ^ f_fn(x[4:7], sk), x[4:7]};
  endfunction

  function automatic logic [0:7] ip(input logic [0:7] x);
    return {x[1], x[5], x[2], x[0], x[3], x[7], x[4], x[6]};
  endfunction

  function automatic logic [0:7] ip_inv(input logic [0:7] x);
    return {x[3], x[0], x[2], x[4], x[6], x[1], x[7], x[5]};
  endfunction

  state_t     state_q, state_d;
  logic [0:7] ct_q, ct_d;
  logic [0:9] key_in_q, key_in_d;
  logic [0:9] stored_key_q, stored_key_d;
  logic       key_held_q, key_held_d;
  logic [0:7] k1_q, k1_d;
  logic [0:7] k2_q, k2_d;
  logic [0:7] mid_q, mid_d;
  logic [0:7] pt_q, pt_d;
  logic       out_valid_q, out_valid_d;

  logic [0:15] subkeys_w;
  logic [0:7]  round1_w;
  logic        reuse_hit_w;

  assign subkeys_w   = keygen(key_in_q);
  assign round1_w    = fk(ip(ct_q), k2_q);
  // Exact 10-bit compare; any key change falls through to KEYGEN.
  assign reuse_hit_w = REUSE_KEY && key_held_q && (bus.key == stored_key_q);

  always_comb begin
    state_d      = state_q;
    ct_d         = ct_q;
    key_in_d     = key_in_q;
    stored_key_d = stored_key_q;
    key_held_d   = key_held_q;
    k1_d         = k1_q;
    k2_d         = k2_q;
    mid_d        = mid_q;
    pt_d         = pt_q;
    out_valid_d  = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ct_d     = bus.ciphertext;
          key_in_d = bus.key;
          state_d  = reuse_hit_w ? ROUND1 : KEYGEN;
        end
      end
      KEYGEN: begin
        k1_d         = subkeys_w[0:7];
        k2_d         = subkeys_w[8:15];
        stored_key_d = key_in_q;
        key_held_d   = 1'b1;
        state_d      = ROUND1;
      end
      ROUND1: begin
        mid_d   = {round1_w[4:7], round1_w[0:3]};  // SW
        state_d = ROUND2;
      end
      ROUND2: begin
        pt_d        = ip_inv(fk(mid_q, k1_q));
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ct_q         <= '0;
      key_in_q     <= '0;
      stored_key_q <= '0;
      key_held_q   <= 1'b0;
      k1_q         <= '0;
      k2_q         <= '0;
      mid_q        <= '0;
      pt_q         <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ct_q         <= ct_d;
      key_in_q     <= key_in_d;
      stored_key_q <= stored_key_d;
      key_held_q   <= key_held_d;
      k1_q         <= k1_d;
      k2_q         <= k2_d;
      mid_q        <= mid_d;
      pt_q         <= pt_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_sdes_decrypt_seq.sv
// Purpose: scoreboard bench for sdes_decrypt_seq (REUSE_KEY=1 and REUSE_KEY=0 instances).
// Latency: checks 3-edge keygen path and 2-edge reuse path from the accept edge.
// Backpressure: holds out_ready low to check the DONE hold behaviour.
module tb_sdes_decrypt_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdes_decrypt_seq_if bus ();
  sdes_decrypt_seq_if bus0 ();

  sdes_decrypt_seq #(.REUSE_KEY(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  sdes_decrypt_seq #(.REUSE_KEY(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp0_q [$];

  // Accept and output-rise counters for the REUSE_KEY=1 instance.
  int   acc_cnt = 0;
  int   ov_rise = 0;
  logic ov_prev = 1'b0;
  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
    if (bus.out_valid && !ov_prev) ov_rise <= ov_rise + 1;
    ov_prev <= bus.out_valid;
  end

  // ---------------- reference encryptor (standard 1-based tables) ----------------
  localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_T  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  localparam int IP_T  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  localparam int IPI_T [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  localparam int EP_T  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  localparam int P4_T  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  localparam int S0_T  [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
  localparam int S1_T  [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

  // Output bit i (1-based from MSB) = input bit t[i] (1-based from MSB).
  function automatic logic [9:0] perm(input logic [9:0] v, input int win, input int wout,
                                      input int t [10]);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < wout; i++) r[wout-1-i] = v[win-t[i]];
    return r;
  endfunction

  function automatic logic [3:0] f_model(input logic [3:0] r, input logic [7:0] sk);
    logic [9:0] e;
    logic [7:0] t;
    logic [3:0] a, b;
    int s0v, s1v;
    e   = perm({6'b0, r}, 4, 8, EP_T);
    t   = e[7:0] ^ sk;
    a   = t[7:4];
    b   = t[3:0];
    s0v = S0_T[{a[3], a[0], a[2], a[1]}];
    s1v = S1_T[{b[3], b[0], b[2], b[1]}];
    e   = perm({6'b0, s0v[1:0], s1v[1:0]}, 4, 4, P4_T);
    return e[3:0];
  endfunction

  function automatic logic [7:0] fk_model(input logic [7:0] x, input logic [7:0] sk);
    return {x[7:4] ^ f_model(x[3:0], sk), x[3:0]};
  endfunction

  function automatic logic [7:0] enc(input logic [9:0] k, input logic [7:0] p);
    logic [9:0] q, e;
    logic [4:0] l, r;
    logic [7:0] k1, k2, x;
    q  = perm(k, 10, 10, P10_T);
    l  = {q[8:5], q[9]};
    r  = {q[3:0], q[4]};
    e  = perm({l, r}, 10, 8, P8_T);
    k1 = e[7:0];
    l  = {l[2:0], l[4:3]};
    r  = {r[2:0], r[4:3]};
    e  = perm({l, r}, 10, 8, P8_T);
    k2 = e[7:0];
    e  = perm({2'b0, p}, 8, 8, IP_T);
    x  = fk_model(e[7:0], k1);
    x  = {x[3:0], x[7:4]};
    x  = fk_model(x, k2);
    e  = perm({2'b0, x}, 8, 8, IPI_T);
    return e[7:0];
  endfunction

  // ---------------- drivers (observe only, no checking) ----------------
  task automatic drive_block(input logic [9:0] k, input logic [7:0] c, output bit accepted);
    int n;
    bus.key        = k;
    bus.ciphertext = c;
    bus.in_valid   = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    accepted = (bus.in_ready === 1'b1);
    if (accepted) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic [7:0] pt, output bit seen);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    seen = (bus.out_valid === 1'b1);
    pt   = bus.plaintext;
  endtask

  task automatic drive_block0(input logic [9:0] k, input logic [7:0] c, output bit accepted);
    int n;
    bus0.key        = k;
    bus0.ciphertext = c;
    bus0.in_valid   = 1'b1;
    n = 0;
    while (bus0.in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    accepted = (bus0.in_ready === 1'b1);
    if (accepted) begin @(posedge clk); #1; end
    bus0.in_valid = 1'b0;
  endtask

  task automatic wait_out0(output int lat, output logic [7:0] pt, output bit seen);
    lat = 0;
    while (bus0.out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    seen = (bus0.out_valid === 1'b1);
    pt   = bus0.plaintext;
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b1;  bus.key = '0;  bus.ciphertext = '0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.key = '0; bus0.ciphertext = '0;
    #12;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.plaintext !== 8'h00) begin bad++; $display("FAIL reset_plaintext got=%h want=00", bus.plaintext); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (dut.key_held_q !== 1'b0) begin bad++; $display("FAIL reset_key_held got=%b want=0", dut.key_held_q); end
    total++; if ({dut.k1_q, dut.k2_q} !== 16'h0000) begin bad++; $display("FAIL reset_subkeys got=%h want=0000", {dut.k1_q, dut.k2_q}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_standard();
    bit acc, seen; int lat; logic [7:0] pt, e;
    exp_q.push_back(8'b01110010);
    drive_block(10'b1010000010, 8'b01110111, acc);
    wait_out(lat, pt, seen);
    e = exp_q.pop_front();
    total++; if (!acc || !seen) begin bad++; $display("FAIL std_handshake acc=%b seen=%b want=1/1", acc, seen); end
    total++; if (lat != 3) begin bad++; $display("FAIL std_latency got=%0d want=3", lat); end
    total++; if (pt !== e) begin bad++; $display("FAIL std_plaintext got=%b want=%b", pt, e); end
    total++; if (dut.k1_q !== 8'b10100100) begin bad++; $display("FAIL std_k1 got=%b want=10100100", dut.k1_q); end
    total++; if (dut.k2_q !== 8'b01000011) begin bad++; $display("FAIL std_k2 got=%b want=01000011", dut.k2_q); end
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL std_release in_ready=%b out_valid=%b want=1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_key_reuse();
    bit acc, seen; int lat; logic [7:0] pt, e;
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'b01110010);
      drive_block(10'b1010000010, 8'b01110111, acc);
      wait_out(lat, pt, seen);
      e = exp_q.pop_front();
      total++; if (!acc || !seen) begin bad++; $display("FAIL reuse_handshake blk=%0d acc=%b seen=%b", i, acc, seen); end
      total++; if (lat != (i == 0 ? 3 : 2)) begin bad++; $display("FAIL reuse_latency blk=%0d got=%0d want=%0d", i, lat, (i == 0 ? 3 : 2)); end
      total++; if (pt !== e) begin bad++; $display("FAIL reuse_plaintext blk=%0d got=%b want=%b", i, pt, e); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      exp0_q.push_back(8'b01110010);
      drive_block0(10'b1010000010, 8'b01110111, acc);
      wait_out0(lat, pt, seen);
      e = exp0_q.pop_front();
      total++; if (!acc || !seen) begin bad++; $display("FAIL noreuse_handshake blk=%0d acc=%b seen=%b", i, acc, seen); end
      total++; if (lat != 3) begin bad++; $display("FAIL noreuse_latency blk=%0d got=%0d want=3", i, lat); end
      total++; if (pt !== e) begin bad++; $display("FAIL noreuse_plaintext blk=%0d got=%b want=%b", i, pt, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    bit acc, seen; int lat; logic [7:0] pt, e; logic [9:0] k; logic [7:0] p;
    k = 10'h2C7; p = 8'h5B;
    bus.out_ready = 1'b0;
    exp_q.push_back(p);
    drive_block(k, enc(k, p), acc);
    wait_out(lat, pt, seen);
    e = exp_q.pop_front();
    total++; if (!seen || pt !== e) begin bad++; $display("FAIL bp_first seen=%b got=%h want=%h", seen, pt, e); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1 || bus.plaintext !== e) begin
        bad++; $display("FAIL bp_hold cyc=%0d out_valid=%b pt=%h want=1/%h", i, bus.out_valid, bus.plaintext, e);
      end
      total++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL bp_status cyc=%0d in_ready=%b busy=%b want=0/1", i, bus.in_ready, bus.busy);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release out_valid=%b in_ready=%b want=0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_sweep();
    bit acc, seen, held; int lat, want_lat, acc0, ov0; logic [7:0] pt, e, p; logic [9:0] k, last_k;
    pulse_reset();
    held = 1'b0; last_k = '0;
    acc0 = acc_cnt; ov0 = ov_rise;
    for (int i = 0; i < 200; i++) begin
      k = (i % 4 == 3) ? last_k : 10'($urandom_range(0, 1023));
      p = 8'($urandom_range(0, 255));
      want_lat = (held && k == last_k) ? 2 : 3;
      held = 1'b1; last_k = k;
      exp_q.push_back(p);
      drive_block(k, enc(k, p), acc);
      wait_out(lat, pt, seen);
      e = exp_q.pop_front();
      total++; if (!acc || !seen || pt !== e) begin
        bad++; $display("FAIL sweep_plaintext blk=%0d key=%h acc=%b seen=%b got=%h want=%h", i, k, acc, seen, pt, e);
      end
      total++; if (lat != want_lat) begin bad++; $display("FAIL sweep_latency blk=%0d got=%0d want=%0d", i, lat, want_lat); end
      @(posedge clk); #1;
    end
    total++; if (ov_rise - ov0 != acc_cnt - acc0 || acc_cnt - acc0 != 200) begin
      bad++; $display("FAIL sweep_counts outputs=%0d accepts=%0d want=200/200", ov_rise - ov0, acc_cnt - acc0);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, seen; int lat; logic [7:0] pt, e; logic [9:0] k;
    k = 10'h1D3;
    pulse_reset();
    exp_q.push_back(8'hA5);
    drive_block(k, enc(k, 8'hA5), acc);
    wait_out(lat, pt, seen);
    e = exp_q.pop_front();
    total++; if (!seen || pt !== e) begin bad++; $display("FAIL mid_setup seen=%b got=%h want=%h", seen, pt, e); end
    @(posedge clk); #1;
    // Same key again: reuse hit lands directly in ROUND1 after the accept edge.
    exp_q.push_back(8'h3C);
    drive_block(k, enc(k, 8'h3C), acc);
    void'(exp_q.pop_front());
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.plaintext !== 8'h00) begin
      bad++; $display("FAIL mid_reset_out out_valid=%b pt=%h want=0/00", bus.out_valid, bus.plaintext);
    end
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_status in_ready=%b busy=%b want=1/0", bus.in_ready, bus.busy);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'h3C);
    drive_block(k, enc(k, 8'h3C), acc);
    wait_out(lat, pt, seen);
    e = exp_q.pop_front();
    total++; if (lat != 3) begin bad++; $display("FAIL mid_after_latency got=%0d want=3", lat); end
    total++; if (!seen || pt !== e) begin bad++; $display("FAIL mid_after_plaintext seen=%b got=%h want=%h", seen, pt, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_input_stability();
    bit acc, seen; int lat, acc0; logic [7:0] pt, e; logic [9:0] k; logic [7:0] p;
    k = 10'h0F6; p = 8'hC3;
    acc0 = acc_cnt;
    exp_q.push_back(p);
    drive_block(k, enc(k, p), acc);
    for (int i = 0; i < 3; i++) begin
      bus.key        = 10'($urandom_range(0, 1023));
      bus.ciphertext = 8'($urandom_range(0, 255));
      bus.in_valid   = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_out(lat, pt, seen);
    e = exp_q.pop_front();
    total++; if (!seen || pt !== e) begin bad++; $display("FAIL stable_plaintext seen=%b got=%h want=%h", seen, pt, e); end
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (acc_cnt - acc0 != 1) begin bad++; $display("FAIL stable_accepts got=%0d want=1", acc_cnt - acc0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_standard();
    test_key_reuse();
    test_backpressure();
    test_sweep();
    test_reset_mid();
    test_input_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
